// File: rtl/mips_isa_pkg.sv
// Shared MIPS instruction-set constants, field positions and the word packer.
// Used by the encoder datapath; the decoder side reads the same field map.
package mips_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'b00,
    FMT_I    = 2'b01,
    FMT_J    = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_t;

  localparam int OP_HI     = 31;
  localparam int OP_LO     = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FUNC_ADD = 6'h20;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [25:0] target;
  } fields_t;

  typedef logic [31:0] word_t;

  // Reserved format packs to zero; the caller is expected to drop it.
  function automatic word_t encode(fmt_t fmt, fields_t f);
    word_t w;
    w = '0;
    case (fmt)
      FMT_R: begin
        w[OP_HI:OP_LO]       = f.op;
        w[RS_HI:RS_LO]       = f.rs;
        w[RT_HI:RT_LO]       = f.rt;
        w[RD_HI:RD_LO]       = f.rd;
        w[SHAMT_HI:SHAMT_LO] = f.shamt;
        w[FUNC_HI:FUNC_LO]   = f.func;
      end
      FMT_I: begin
        w[OP_HI:OP_LO]   = f.op;
        w[RS_HI:RS_LO]   = f.rs;
        w[RT_HI:RT_LO]   = f.rt;
        w[IMM_HI:IMM_LO] = f.imm16;
      end
      FMT_J: begin
        w[OP_HI:OP_LO]         = f.op;
        w[TARGET_HI:TARGET_LO] = f.target;
      end
      FMT_RSVD: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational R/I/J packer: field tuple in, 32-bit word and reserved flag out.
// Latency: zero (pure logic). Backpressure: none, it never stalls.
module instr_pack
  import mips_isa_pkg::*;
(
  input  fmt_t        fmt,
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        rsvd
);

  always_comb begin
    word = encode(fmt, fields);
    rsvd = (fmt == FMT_RSVD);
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS field-tuple encoder that loads words into instruction memory.
// Latency: accept-to-write 1 cycle, one write per cycle when fed back-to-back.
// Backpressure: in_ready low outside LOAD, during start, or once DEPTH words are written.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   fmt,
  input  logic [5:0]                   op,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   shamt,
  input  logic [5:0]                   func,
  input  logic [15:0]                  imm16,
  input  logic [25:0]                  target,
  input  logic                         last,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state;
  fields_t       fields;
  logic [31:0]   pack_word;
  logic          pack_rsvd;
  logic          accept;
  logic [CW-1:0] count_inc;

  assign fields = '{op: op, rs: rs, rt: rt, rd: rd, shamt: shamt,
                    func: func, imm16: imm16, target: target};

  instr_pack u_pack (
    .fmt    (fmt_t'(fmt)),
    .fields (fields),
    .word   (pack_word),
    .rsvd   (pack_rsvd)
  );

  assign busy      = (state == LOAD);
  assign done      = (state == DONE);
  assign in_ready  = busy && !start && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + CW'(1);

  // start outranks any same-cycle handshake; a write registered on the
  // previous edge has already reached mem_we and is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        state <= LOAD;
        count <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (pack_rsvd) begin
          err <= 1'b1;
          if (last) state <= DONE;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE_ADDR + (32'(count) << 2);
          mem_wdata <= pack_word;
          count     <= count_inc;
          if (last || (count_inc == DEPTH_C)) state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table plus restart/full/reset sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        last = 1'b0;
  logic [1:0]  fmt = 2'b00;
  logic [5:0]  op = 6'h00;
  logic [4:0]  rs = 5'h00, rt = 5'h00, rd = 5'h00, shamt = 5'h00;
  logic [5:0]  func = 6'h00;
  logic [15:0] imm16 = 16'h0000;
  logic [25:0] target = 26'h0;

  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm16(imm16), .target(target), .last(last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic        we;
    logic [31:0] addr, wd;
    logic [2:0]  cnt;
    logic        dn, er;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic st, logic [1:0] f, logic [5:0] o, logic [4:0] s,
                              logic [4:0] t, logic [4:0] d, logic [4:0] sh,
                              logic [5:0] fn, logic [15:0] im, logic [25:0] tg,
                              logic lst, logic we, logic [31:0] a, logic [31:0] wd,
                              logic [2:0] c, logic dn, logic er);
    vec_t v;
    v.st = st; v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.sh = sh;
    v.func = fn; v.imm = im; v.tgt = tg; v.last = lst; v.we = we; v.addr = a;
    v.wd = wd; v.cnt = c; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
    func = v.func; imm16 = v.imm; target = v.tgt; last = v.last;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // add r17,r18,r19 as an R-type tuple, reused by the hand-written sequences
  task automatic drive_add();
    fmt = 2'b00; op = 6'h00; rs = 5'd18; rt = 5'd19; rd = 5'd17; shamt = 5'd0;
    func = 6'h20; imm16 = 16'h0; target = 26'h0; last = 1'b0;
  endtask

  initial begin
    //          st fmt    op     rs     rt     rd     sh     func   imm       tgt         lst  we   addr   wdata          cnt   dn   er
    tbl[0] = mk(1, 2'b00, 6'h00, 5'd18, 5'd19, 5'd17, 5'd0,  6'h20, 16'h0000, 26'h0,      0, 1, 32'h0, 32'h02538820, 3'd1, 0, 0);
    tbl[1] = mk(0, 2'b01, 6'h2b, 5'd17, 5'd18, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,      1, 1, 32'h4, 32'hae320000, 3'd2, 1, 0);
    tbl[2] = mk(1, 2'b10, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h0000C00, 0, 1, 32'h0, 32'h08000C00, 3'd1, 0, 0);
    tbl[3] = mk(0, 2'b00, 6'h00, 5'd1,  5'd2,  5'd3,  5'd4,  6'h22, 16'hffff, 26'h3ffffff, 0, 1, 32'h4, 32'h00221922, 3'd2, 0, 0);
    tbl[4] = mk(0, 2'b01, 6'h23, 5'd29, 5'd8,  5'h1f, 5'h1f, 6'h3f, 16'hfffc, 26'h3ffffff, 0, 1, 32'h8, 32'h8fa8fffc, 3'd3, 0, 0);
    tbl[5] = mk(0, 2'b01, 6'h04, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'h0003, 26'h0,      1, 1, 32'hc, 32'h10220003, 3'd4, 1, 0);
    tbl[6] = mk(1, 2'b00, 6'h00, 5'd18, 5'd19, 5'd17, 5'd0,  6'h20, 16'h0000, 26'h0,      0, 1, 32'h0, 32'h02538820, 3'd1, 0, 0);
    tbl[7] = mk(0, 2'b11, 6'h3f, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h3ffffff, 0, 0, 32'h0, 32'h02538820, 3'd1, 0, 1);
    tbl[8] = mk(0, 2'b01, 6'h2b, 5'd17, 5'd18, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,      0, 1, 32'h4, 32'hae320000, 3'd2, 0, 1);
    tbl[9] = mk(0, 2'b11, 6'h23, 5'd1,  5'd2,  5'd3,  5'd4,  6'h05, 16'h1234, 26'h0,      1, 0, 32'h4, 32'hae320000, 3'd2, 1, 1);

    // reset state
    #1 rst = 1'b1;
    #2 chk_all_zero("rst");
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    step();
    chk_all_zero("idle_ignores_valid");
    in_valid = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].st) begin
        pulse_start();
        chk($sformatf("v%0d_start_busy", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_start_count", i), 32'(count), 32'd0);
        chk($sformatf("v%0d_start_err", i), 32'(err), 32'd0);
      end
      drive(tbl[i]);
      in_valid = 1'b1;
      #1 chk($sformatf("v%0d_in_ready_pre", i), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      last = 1'b0;
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(!tbl[i].dn));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("v%0d_in_ready_post", i), 32'(in_ready),
          32'(!tbl[i].dn && (tbl[i].cnt < 3'd4)));
    end

    // fill to DEPTH with in_valid held and no last
    pulse_start();
    drive_add();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("full%0d_mem_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("full%0d_mem_addr", k), mem_addr, 32'(4 * k));
      chk($sformatf("full%0d_count", k), 32'(count), 32'(k + 1));
      chk($sformatf("full%0d_in_ready", k), 32'(in_ready), 32'(k < 3));
    end
    chk("full_done", 32'(done), 32'd1);
    step();
    chk("full_after_mem_we", 32'(mem_we), 32'd0);
    chk("full_after_count", 32'(count), 32'd4);
    chk("full_after_addr_hold", mem_addr, 32'hc);
    in_valid = 1'b0;

    // restart mid-session with a same-cycle tuple
    pulse_start();
    fmt = 2'b11;
    in_valid = 1'b1;
    step();
    chk("rs_err_set", 32'(err), 32'd1);
    drive_add();
    step();
    chk("rs_write_mem_we", 32'(mem_we), 32'd1);
    chk("rs_write_count", 32'(count), 32'd1);
    start = 1'b1;
    #1 chk("rs_start_in_ready", 32'(in_ready), 32'd0);
    chk("rs_pending_mem_we", 32'(mem_we), 32'd1);
    step();
    start = 1'b0;
    chk("rs_after_count", 32'(count), 32'd0);
    chk("rs_after_err", 32'(err), 32'd0);
    chk("rs_after_mem_we", 32'(mem_we), 32'd0);
    chk("rs_after_busy", 32'(busy), 32'd1);
    step();
    chk("rs_next_mem_we", 32'(mem_we), 32'd1);
    chk("rs_next_addr", mem_addr, 32'h0);
    chk("rs_next_count", 32'(count), 32'd1);
    step();
    chk("rs_second_addr", mem_addr, 32'h4);
    chk("rs_second_count", 32'(count), 32'd2);

    // asynchronous reset mid-stream, with a write on mem_we
    rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d_mem_we", k), 32'(mem_we), 32'd0);
      chk($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
      chk($sformatf("post_rst%0d_count", k), 32'(count), 32'd0);
    end
    start = 1'b1;
    #1 chk("post_rst_busy_pre", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd1);
    step();
    in_valid = 1'b0;
    chk("post_rst_mem_we", 32'(mem_we), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_wdata", mem_wdata, 32'h02538820);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
